shift_issue_reg: RTL and testbench



---
 rtl/shift_pkg.sv | 38 +++
 rtl/shift_decode.sv | 70 +++++++
 rtl/shift_issue_reg.sv | 145 ++++++++++++++
 tb/tb_shift_issue_reg.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the ID/EX shift issue register.
// Optional feature macro: SHIFT_SRA_EN (arithmetic right shifts SRA/SRAV).
package shift_pkg;

  // Widths of the stored entry; the top-level parameters must match these.
  localparam int DATA_W_P  = 32;
  localparam int SHAMT_W_P = 5;
  localparam int REG_AW_P  = 5;

  // R-type opcode and the shift function codes.
  localparam logic [5:0] OPC_RTYPE  = 6'b000000;
  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  // Occupancy of the main/skid buffer pair.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  // One decoded instruction as seen by the EX-stage shifter.
  typedef struct packed {
    logic [DATA_W_P-1:0]  datain;
    logic [SHAMT_W_P-1:0] shftamt;
    logic                 len;
    logic                 ren;
    logic                 arith;
    logic                 is_shift;
    logic [REG_AW_P-1:0]  dest;
    logic                 we;
  } shift_entry_t;

endpackage

// File: rtl/shift_decode.sv
// Combinational decode of an ID-stage instruction into a shifter entry.
// Optional feature macro: SHIFT_SRA_EN adds SRA/SRAV decode.
module shift_decode
  import shift_pkg::*;
(
  input  logic [31:0]         i_instr,
  input  logic [DATA_W_P-1:0] i_rs_data,
  input  logic [DATA_W_P-1:0] i_rt_data,
  output shift_entry_t        o_entry
);

  logic [5:0] w_opc;
  logic [5:0] w_funct;
  logic       w_unused_bits;

  assign w_opc   = i_instr[31:26];
  assign w_funct = i_instr[5:0];
  // rs/rt register fields and upper rs bits play no part in shift decode.
  assign w_unused_bits = ^{i_instr[25:16], i_rs_data[DATA_W_P-1:SHAMT_W_P]};

  // Decode opcode/funct into shift controls; non-shifts pass through as no-ops.
  always_comb begin
    // NOTE: every field gets a default first so no path leaves one unassigned (no latch).
    o_entry        = '0;
    o_entry.datain = i_rt_data;
    o_entry.dest   = i_instr[15:11];
    if (w_opc == OPC_RTYPE) begin
      case (w_funct)
        FUNCT_SLL: begin
          o_entry.is_shift = 1'b1;
          o_entry.len      = 1'b1;
          o_entry.shftamt  = i_instr[10:6];
        end
        FUNCT_SRL: begin
          o_entry.is_shift = 1'b1;
          o_entry.ren      = 1'b1;
          o_entry.shftamt  = i_instr[10:6];
        end
        FUNCT_SLLV: begin
          o_entry.is_shift = 1'b1;
          o_entry.len      = 1'b1;
          o_entry.shftamt  = i_rs_data[SHAMT_W_P-1:0];
        end
        FUNCT_SRLV: begin
          o_entry.is_shift = 1'b1;
          o_entry.ren      = 1'b1;
          o_entry.shftamt  = i_rs_data[SHAMT_W_P-1:0];
        end
`ifdef SHIFT_SRA_EN
        FUNCT_SRA: begin
          o_entry.is_shift = 1'b1;
          o_entry.ren      = 1'b1;
          o_entry.arith    = 1'b1;
          o_entry.shftamt  = i_instr[10:6];
        end
        FUNCT_SRAV: begin
          o_entry.is_shift = 1'b1;
          o_entry.ren      = 1'b1;
          o_entry.arith    = 1'b1;
          o_entry.shftamt  = i_rs_data[SHAMT_W_P-1:0];
        end
`endif
        default: ;
      endcase
    end
    // Writes to r0 are suppressed, so the all-zero NOP never writes.
    o_entry.we = o_entry.is_shift && (o_entry.dest != '0);
  end

endmodule

// File: rtl/shift_issue_reg.sv
// ID/EX stage register for the shift datapath: decodes shift instructions
// and holds them in a main + skid buffer so EX stalls stay registered.
// Optional feature macro: SHIFT_SRA_EN adds the ex_shift_arith output.
module shift_issue_reg
  import shift_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int REG_AW  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [31:0]        id_instr,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic               ex_ready,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_datain,
  output logic [SHAMT_W-1:0] ex_shftamt,
  output logic               ex_shift_len,
  output logic               ex_shift_ren,
  output logic               ex_is_shift,
  output logic [REG_AW-1:0]  ex_dest,
  output logic               ex_we
`ifdef SHIFT_SRA_EN
  ,
  output logic               ex_shift_arith
`endif
);

  state_t       r_state;
  state_t       w_next_state;
  shift_entry_t r_main;
  shift_entry_t r_skid;
  shift_entry_t w_dec;
  logic         r_id_ready;
  logic         w_accept;
  logic         w_retire;
  logic         w_valid;
  logic         w_load_main;
  logic         w_load_skid;
  logic         w_main_from_skid;

  shift_decode u_decode (
    .i_instr   (id_instr),
    .i_rs_data (id_rs_data),
    .i_rt_data (id_rt_data),
    .o_entry   (w_dec)
  );

  assign w_valid  = (r_state != EMPTY);
  assign w_accept = id_valid && r_id_ready;
  assign w_retire = w_valid && ex_ready;

  // Next-state and buffer load selection; flush overrides every transfer.
  always_comb begin
    w_next_state     = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    if (flush) begin
      w_next_state = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_next_state = BUSY;
            w_load_main  = 1'b1;
          end
        end
        BUSY: begin
          case ({w_accept, w_retire})
            2'b11: w_load_main = 1'b1;
            2'b10: begin
              w_next_state = FULL;
              w_load_skid  = 1'b1;
            end
            2'b01:   w_next_state = EMPTY;
            default: ;
          endcase
        end
        FULL: begin
          if (w_retire) begin
            w_next_state     = BUSY;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_next_state = EMPTY;
      endcase
    end
  end

  // State register; id_ready is registered from the next state so EX stalls
  // never reach ID combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_id_ready <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_state    <= w_next_state;
      r_id_ready <= (w_next_state != FULL);
    end
  end

  // Entry storage: main feeds EX, skid catches one extra entry during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload is reset only for deterministic X-free outputs; validity lives in r_state.
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_main_from_skid) begin
        r_main <= r_skid;
      end else if (w_load_main) begin
        r_main <= w_dec;
      end
      if (w_load_skid) begin
        r_skid <= w_dec;
      end
    end
  end

  // All EX outputs read zero whenever no entry is present.
  assign id_ready     = r_id_ready;
  assign ex_valid     = w_valid;
  assign ex_datain    = w_valid ? r_main.datain  : '0;
  assign ex_shftamt   = w_valid ? r_main.shftamt : '0;
  assign ex_shift_len = w_valid && r_main.len;
  assign ex_shift_ren = w_valid && r_main.ren;
  assign ex_is_shift  = w_valid && r_main.is_shift;
  assign ex_dest      = w_valid ? r_main.dest    : '0;
  assign ex_we        = w_valid && r_main.we;

`ifdef SHIFT_SRA_EN
  assign ex_shift_arith = w_valid && r_main.arith;
`else
  logic w_unused_arith;
  assign w_unused_arith = r_main.arith;
`endif

endmodule

// File: tb/tb_shift_issue_reg.sv
// Self-checking bench for shift_issue_reg: directed vector table, hand-written
// backpressure/flush/reset sequences and randomized traffic against a
// queue-based reference model. Honours SHIFT_SRA_EN if defined.
module tb_shift_issue_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_datain;
  logic [4:0]  ex_shftamt;
  logic        ex_shift_len;
  logic        ex_shift_ren;
  logic        ex_is_shift;
  logic [4:0]  ex_dest;
  logic        ex_we;
`ifdef SHIFT_SRA_EN
  logic        ex_shift_arith;
`endif

  always #5 clk = ~clk;

  shift_issue_reg dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_instr     (id_instr),
    .id_rs_data   (id_rs_data),
    .id_rt_data   (id_rt_data),
    .ex_ready     (ex_ready),
    .ex_valid     (ex_valid),
    .ex_datain    (ex_datain),
    .ex_shftamt   (ex_shftamt),
    .ex_shift_len (ex_shift_len),
    .ex_shift_ren (ex_shift_ren),
    .ex_is_shift  (ex_is_shift),
    .ex_dest      (ex_dest),
    .ex_we        (ex_we)
`ifdef SHIFT_SRA_EN
    ,
    .ex_shift_arith (ex_shift_arith)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] datain;
    logic [4:0]  amt;
    logic        len;
    logic        ren;
    logic        arith;
    logic        is_shift;
    logic [4:0]  dest;
    logic        we;
  } exp_t;

  exp_t q[$];          // entries visible to EX, oldest first (at most two)
  logic m_ready = 1'b1;

  function automatic exp_t ref_decode(input logic [31:0] instr, input logic [31:0] rs,
                                      input logic [31:0] rt);
    exp_t e;
    e        = '{default: '0};
    e.datain = rt;
    e.dest   = instr[15:11];
    if (instr[31:26] == 6'd0) begin
      case (instr[5:0])
        6'h00: begin e.len = 1'b1; e.amt = instr[10:6]; end
        6'h02: begin e.ren = 1'b1; e.amt = instr[10:6]; end
        6'h04: begin e.len = 1'b1; e.amt = rs[4:0]; end
        6'h06: begin e.ren = 1'b1; e.amt = rs[4:0]; end
`ifdef SHIFT_SRA_EN
        6'h03: begin e.ren = 1'b1; e.arith = 1'b1; e.amt = instr[10:6]; end
        6'h07: begin e.ren = 1'b1; e.arith = 1'b1; e.amt = rs[4:0]; end
`endif
        default: ;
      endcase
      e.is_shift = e.len | e.ren;
    end
    e.we = e.is_shift && (e.dest != 5'd0);
    return e;
  endfunction

  task automatic check_model(input string tag);
    exp_t e;
    e = '{default: '0};
    if (q.size() > 0) e = q[0];
    check({tag, "_valid"}, 32'(ex_valid), 32'(q.size() > 0));
    check({tag, "_id_ready"}, 32'(id_ready), 32'(m_ready));
    check({tag, "_datain"}, ex_datain, e.datain);
    check({tag, "_amt"}, 32'(ex_shftamt), 32'(e.amt));
    check({tag, "_len"}, 32'(ex_shift_len), 32'(e.len));
    check({tag, "_ren"}, 32'(ex_shift_ren), 32'(e.ren));
    check({tag, "_is_shift"}, 32'(ex_is_shift), 32'(e.is_shift));
    check({tag, "_dest"}, 32'(ex_dest), 32'(e.dest));
    check({tag, "_we"}, 32'(ex_we), 32'(e.we));
`ifdef SHIFT_SRA_EN
    check({tag, "_arith"}, 32'(ex_shift_arith), 32'(e.arith));
`endif
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                      input logic [31:0] rt, input logic rdy, input logic fl,
                      input string tag);
    logic acc;
    logic ret;
    exp_t e;
    id_valid   = v;
    id_instr   = ins;
    id_rs_data = rs;
    id_rt_data = rt;
    ex_ready   = rdy;
    flush      = fl;
    acc = v && m_ready;
    ret = (q.size() > 0) && rdy;
    e   = ref_decode(ins, rs, rt);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (ret) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    m_ready = (q.size() < 2);
    #1;
    check_model(tag);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        is_shift;
    logic        len;
    logic        ren;
    logic        arith;
    logic [4:0]  amt;
    logic [4:0]  dest;
    logic        we;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] rs,
                              input logic [31:0] rt, input logic sh, input logic len,
                              input logic ren, input logic ar, input logic [4:0] amt,
                              input logic [4:0] dest, input logic we);
    vec_t v;
    v.instr = instr; v.rs = rs; v.rt = rt; v.is_shift = sh; v.len = len;
    v.ren = ren; v.arith = ar; v.amt = amt; v.dest = dest; v.we = we;
    return v;
  endfunction

  localparam logic [31:0] I1 = 32'h0000_5040;  // SLL  rd=10 shamt=1
  localparam logic [31:0] I2 = 32'h0000_5882;  // SRL  rd=11 shamt=2
  localparam logic [31:0] I3 = 32'h0000_6004;  // SLLV rd=12

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    vec_t vt[9];
    rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; id_instr = '0;
    id_rs_data = '0; id_rt_data = '0; ex_ready = 1'b0;

    vt[0] = mk(32'h0000_1900, 32'h0, 32'h0000_00F0, 1, 1, 0, 0, 5'd4, 5'd3, 1);   // SLL
    vt[1] = mk(32'h0000_2806, 32'hFFFF_FFE7, 32'h1234_5678, 1, 0, 1, 0, 5'd7, 5'd5, 1); // SRLV
    vt[2] = mk(32'h0000_0000, 32'h0, 32'h5555_AAAA, 1, 1, 0, 0, 5'd0, 5'd0, 0);   // NOP
    vt[3] = mk(32'h0000_3A60, 32'h1F, 32'hCAFE_0001, 0, 0, 0, 0, 5'd0, 5'd7, 0);  // ADD
`ifdef SHIFT_SRA_EN
    vt[4] = mk(32'h0000_17C3, 32'h0, 32'h8000_0000, 1, 0, 1, 1, 5'd31, 5'd2, 1);  // SRA
`else
    vt[4] = mk(32'h0000_17C3, 32'h0, 32'h8000_0000, 0, 0, 0, 0, 5'd0, 5'd2, 0);   // SRA off
`endif
    vt[5] = mk(32'h0000_F842, 32'h0, 32'hFFFF_FFFF, 1, 0, 1, 0, 5'd1, 5'd31, 1);  // SRL
    vt[6] = mk(32'h0000_0804, 32'h23, 32'h0000_0001, 1, 1, 0, 0, 5'd3, 5'd1, 1);  // SLLV
    vt[7] = mk(32'h8C00_1900, 32'h0, 32'h0000_0077, 0, 0, 0, 0, 5'd0, 5'd3, 0);   // non-R
`ifdef SHIFT_SRA_EN
    vt[8] = mk(32'h0000_2007, 32'h1F, 32'hF000_0000, 1, 0, 1, 1, 5'd31, 5'd4, 1); // SRAV
`else
    vt[8] = mk(32'h0000_2007, 32'h1F, 32'hF000_0000, 0, 0, 0, 0, 5'd0, 5'd4, 0);  // SRAV off
`endif

    // Reset state.
    #12;
    check("reset_valid", 32'(ex_valid), 32'd0);
    check("reset_id_ready", 32'(id_ready), 32'd1);
    check("reset_datain", ex_datain, 32'd0);
    check("reset_dest", 32'(ex_dest), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: ex_ready=1, one new entry visible each cycle after acceptance.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, vt[i].instr, vt[i].rs, vt[i].rt, 1'b1, 1'b0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_t_valid", i), 32'(ex_valid), 32'd1);
      check($sformatf("vec%0d_t_datain", i), ex_datain, vt[i].rt);
      check($sformatf("vec%0d_t_amt", i), 32'(ex_shftamt), 32'(vt[i].amt));
      check($sformatf("vec%0d_t_len", i), 32'(ex_shift_len), 32'(vt[i].len));
      check($sformatf("vec%0d_t_ren", i), 32'(ex_shift_ren), 32'(vt[i].ren));
      check($sformatf("vec%0d_t_is_shift", i), 32'(ex_is_shift), 32'(vt[i].is_shift));
      check($sformatf("vec%0d_t_dest", i), 32'(ex_dest), 32'(vt[i].dest));
      check($sformatf("vec%0d_t_we", i), 32'(ex_we), 32'(vt[i].we));
`ifdef SHIFT_SRA_EN
      check($sformatf("vec%0d_t_arith", i), 32'(ex_shift_arith), 32'(vt[i].arith));
`endif
    end
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, "drain");
    check("drain_valid", 32'(ex_valid), 32'd0);

    // Backpressure: three back-to-back offers with EX stalled.
    step(1'b1, I1, 32'h0, 32'h11, 1'b0, 1'b0, "bp1");
    check("bp1_dest", 32'(ex_dest), 32'd10);
    check("bp1_ready", 32'(id_ready), 32'd1);
    step(1'b1, I2, 32'h0, 32'h22, 1'b0, 1'b0, "bp2");
    check("bp2_dest", 32'(ex_dest), 32'd10);
    check("bp2_ready", 32'(id_ready), 32'd0);
    step(1'b1, I3, 32'h3, 32'h33, 1'b0, 1'b0, "bp3");
    check("bp3_dest_held", 32'(ex_dest), 32'd10);
    check("bp3_datain_held", ex_datain, 32'h11);
    check("bp3_ready", 32'(id_ready), 32'd0);
    step(1'b1, I3, 32'h3, 32'h33, 1'b1, 1'b0, "bp4");
    check("bp4_dest", 32'(ex_dest), 32'd11);
    check("bp4_ready", 32'(id_ready), 32'd1);
    step(1'b1, I3, 32'h3, 32'h33, 1'b1, 1'b0, "bp5");
    check("bp5_dest", 32'(ex_dest), 32'd12);
    check("bp5_amt", 32'(ex_shftamt), 32'd3);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, "bp6");
    check("bp6_valid", 32'(ex_valid), 32'd0);

    // Flush while FULL with a same-cycle offer.
    step(1'b1, I1, 32'h0, 32'h44, 1'b0, 1'b0, "fl1");
    step(1'b1, I2, 32'h0, 32'h55, 1'b0, 1'b0, "fl2");
    check("fl2_full_ready", 32'(id_ready), 32'd0);
    step(1'b1, I3, 32'h0, 32'h66, 1'b0, 1'b1, "fl3");
    check("fl3_valid", 32'(ex_valid), 32'd0);
    check("fl3_ready", 32'(id_ready), 32'd1);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, "fl4");
    check("fl4_valid", 32'(ex_valid), 32'd0);

    // Asynchronous reset mid-cycle while BUSY.
    step(1'b1, I1, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, "ar1");
    check("ar1_busy_valid", 32'(ex_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(ex_valid), 32'd0);
    check("ar_ready", 32'(id_ready), 32'd1);
    check("ar_datain", ex_datain, 32'd0);
    check("ar_dest", 32'(ex_dest), 32'd0);
    check("ar_len", 32'(ex_shift_len), 32'd0);
    q.delete();
    m_ready = 1'b1;
    #2;
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [5:0]  opc;
      logic [5:0]  fn;
      logic [31:0] ins;
      int          pick;
      opc  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
      pick = $urandom_range(0, 8);
      case (pick)
        0: fn = 6'h00;
        1: fn = 6'h02;
        2: fn = 6'h03;
        3: fn = 6'h04;
        4: fn = 6'h06;
        5: fn = 6'h07;
        6: fn = 6'h20;
        default: fn = 6'($urandom);
      endcase
      ins = {opc, 10'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom), 5'($urandom), fn};
      step($urandom_range(0, 3) != 0, ins, $urandom, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
